// File: rtl/memory_stream_pkg.sv
// Shared types for the memory stream reader: controller state encoding and
// the depth of the output skid FIFO.
package memory_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ms_state_e;

  // Two entries cover the one-cycle memory latency plus one word held under
  // backpressure, which is what keeps throughput at one word per cycle.
  localparam int unsigned MS_FIFO_DEPTH = 2;

endpackage

// File: rtl/memory_stream_skid.sv
// Two-entry FIFO that absorbs the registered read latency of the memory.
// The head entry is presented combinationally; push and pop may coincide.
module memory_stream_skid
  import memory_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_last_o
);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t     mem_q [MS_FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  // Storage, pointers and occupancy; the caller never pushes into a full FIFO
  // without popping in the same cycle, nor pops an empty one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MS_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= '{last: push_last_i, data: push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q].data;
  assign head_last_o = mem_q[rd_ptr_q].last;

endmodule

// File: rtl/memory_stream_reader.sv
// Read-side initiator for a single memory port: takes a (base, count)
// command, walks the addresses, and streams the returned words out with a
// last flag. Optional feature macro: MEMORY_STREAM_READER_STRIDE_EN adds a
// cmdStride port; without it the address step is fixed at 1.
//
// state | meaning
// IDLE  | cmdReady high, waiting for a non-zero-count command
// RUN   | issuing addresses while FIFO + in-flight credit allows
// DRAIN | all addresses issued, waiting for the last word to be popped
module memory_stream_reader
  import memory_stream_pkg::*;
#(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [AW-1:0]    cmdBase,
  input  logic [AW:0]      cmdCount,
`ifdef MEMORY_STREAM_READER_STRIDE_EN
  input  logic [AW-1:0]    cmdStride,
`endif
  output logic [AW-1:0]    memAddress,
  output logic             memWriteEnable,
  output logic [WIDTH-1:0] memWrite,
  input  logic [WIDTH-1:0] memRead,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData,
  output logic             outLast
);

  ms_state_e        state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW:0]      remaining_q, remaining_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;
  logic [AW-1:0]    step;
  logic [1:0]       fifo_count;
  logic [2:0]       occupancy;
  logic [WIDTH-1:0] head_data;
  logic             head_last;
  logic             pop, credit, issue, cmd_fire;

`ifdef MEMORY_STREAM_READER_STRIDE_EN
  logic [AW-1:0]    stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = AW'(1);
`endif

  assign cmd_fire  = cmdValid && cmdReady;
  assign pop       = outValid && outReady;
  // A word in flight already owns a FIFO slot; a pop this cycle frees one.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit    = (occupancy < 3'd2) || pop;
  assign issue     = (state_q == RUN) && credit;

  // Next-state, address walk and in-flight tagging.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
`ifdef MEMORY_STREAM_READER_STRIDE_EN
    stride_d        = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_fire && (cmdCount != '0)) begin
          addr_d      = cmdBase;
          remaining_d = cmdCount;
`ifdef MEMORY_STREAM_READER_STRIDE_EN
          stride_d    = cmdStride;
`endif
          state_d     = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d          = addr_q + step;
          remaining_d     = remaining_q - (AW+1)'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (remaining_q == (AW+1)'(1));
          if (remaining_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset aborts any command in progress.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef MEMORY_STREAM_READER_STRIDE_EN
      stride_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
`ifdef MEMORY_STREAM_READER_STRIDE_EN
      stride_q        <= stride_d;
`endif
    end
  end

  memory_stream_skid #(.WIDTH(WIDTH)) u_skid (
    .clock       (clock),
    .resetn      (resetn),
    .push_i      (inflight_q),
    .push_data_i (memRead),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_data_o (head_data),
    .head_last_o (head_last)
  );

  assign cmdReady       = (state_q == IDLE);
  assign memAddress     = addr_q;
  assign memWriteEnable = 1'b0;
  assign memWrite       = '0;
  assign outValid       = (fifo_count != 2'd0);
  assign outData        = head_data;
  assign outLast        = outValid && head_last;

endmodule

// File: tb/tb_memory_stream_reader.sv
// Bench for memory_stream_reader: registered-read memory model, scoreboard
// queue filled at each command handshake, and a negedge monitor that pops and
// compares every accepted output word.
module tb_memory_stream_reader;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 4;

  logic             clock    = 1'b0;
  logic             resetn   = 1'b0;
  logic             cmdValid = 1'b0;
  logic             cmdReady;
  logic [AW-1:0]    cmdBase  = '0;
  logic [AW:0]      cmdCount = '0;
`ifdef MEMORY_STREAM_READER_STRIDE_EN
  logic [AW-1:0]    cmdStride = '0;
`endif
  logic [AW-1:0]    memAddress;
  logic             memWriteEnable;
  logic [WIDTH-1:0] memWrite;
  logic [WIDTH-1:0] memRead;
  logic             outValid;
  logic             outReady = 1'b1;
  logic [WIDTH-1:0] outData;
  logic             outLast;

  memory_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .cmdValid       (cmdValid),
    .cmdReady       (cmdReady),
    .cmdBase        (cmdBase),
    .cmdCount       (cmdCount),
`ifdef MEMORY_STREAM_READER_STRIDE_EN
    .cmdStride      (cmdStride),
`endif
    .memAddress     (memAddress),
    .memWriteEnable (memWriteEnable),
    .memWrite       (memWrite),
    .memRead        (memRead),
    .outValid       (outValid),
    .outReady       (outReady),
    .outData        (outData),
    .outLast        (outLast)
  );

  always #5 clock = ~clock;

  // Synchronous memory with one-cycle registered read, mem[i] = 100 + i.
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(100 + i);
  always @(posedge clock) memRead <= mem[memAddress];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    int               cyc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;
  int rmode = 0;
  int ph    = 0;
  bit occ_en = 1'b0;
  int occ_base = 0;
  int occ_pop0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: occupancy bound, then pop-and-compare on every accepted word.
  exp_t e;
  int   issued;
  always @(negedge clock) begin
    if (resetn) begin
      if (occ_en && !cmdReady) begin
        issued = ((int'(memAddress) - occ_base) % DEPTH + DEPTH) % DEPTH;
        check("occupancy_le2", 64'(issued - (n_pop - occ_pop0) <= 2), 64'd1);
      end
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got data %0d with nothing expected (cycle %0d)", outData, cyc);
        end else begin
          e = sb.pop_front();
          check("data", 64'(outData), 64'(e.data));
          check("last", 64'(outLast), 64'(e.last));
          if (e.cyc >= 0) check("word_cycle", 64'(cyc), 64'(e.cyc));
        end
        n_pop++;
      end
    end
  end

  // outReady driver: 0 = always high, 1 = random, 2 = alternating with a 5-cycle low burst.
  initial forever begin
    @(posedge clock);
    #1;
    case (rmode)
      1: outReady = 1'($urandom_range(0, 1));
      2: begin
        outReady = (ph >= 6 && ph < 11) ? 1'b0 : ((ph % 2) == 0);
        ph++;
      end
      default: outReady = 1'b1;
    endcase
  end

  task automatic send_cmd(input int base, input int count, input int stride, input bit timed);
    int   hs;
    int   w;
    int   a;
    exp_t x;
    @(posedge clock);
    #1;
    cmdValid = 1'b1;
    cmdBase  = AW'(base);
    cmdCount = (AW+1)'(count);
`ifdef MEMORY_STREAM_READER_STRIDE_EN
    cmdStride = AW'(stride);
`endif
    w = 0;
    while (!cmdReady && w < 500) begin
      @(posedge clock);
      #1;
      w++;
    end
    if (!cmdReady) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_accept_timeout: cmdReady got 0 expected 1");
      cmdValid = 1'b0;
      return;
    end
    hs = cyc;
    for (int k = 0; k < count; k++) begin
      a      = (base + k * stride) % DEPTH;
      x.data = WIDTH'(100 + a);
      x.last = (k == count - 1);
      x.cyc  = timed ? hs + 3 + k : -1;
      sb.push_back(x);
    end
    occ_base = base;
    occ_pop0 = n_pop;
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
    if (count == 0) begin
      check("zero_cmdready", 64'(cmdReady), 64'd1);
      for (int k = 0; k < 5; k++) begin
        @(negedge clock);
        check("zero_no_valid", 64'(outValid), 64'd0);
      end
    end else begin
      w = 0;
      while (!cmdReady && w < 2000) begin
        @(posedge clock);
        #1;
        w++;
      end
      check("cmdready_return", 64'(cmdReady), 64'd1);
      if (timed) check("cmdready_cycle", 64'(cyc), 64'(hs + count + 3));
      check("sb_drained", 64'(sb.size()), 64'd0);
    end
  endtask

  initial begin
    int p0;
    int w;
    int base;
    int count;
    int stride;

    repeat (3) @(posedge clock);
    #1;
    check("rst_cmdReady", 64'(cmdReady), 64'd1);
    check("rst_outValid", 64'(outValid), 64'd0);
    check("rst_outLast", 64'(outLast), 64'd0);
    check("rst_outData", 64'(outData), 64'd0);
    check("rst_memAddress", 64'(memAddress), 64'd0);
    check("rst_memWriteEnable", 64'(memWriteEnable), 64'd0);
    check("rst_memWrite", 64'(memWrite), 64'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    send_cmd(3, 4, 1, 1'b1);
    send_cmd(14, 4, 1, 1'b1);

    ph     = 0;
    rmode  = 2;
    occ_en = 1'b1;
    send_cmd(0, 8, 1, 1'b0);
    occ_en = 1'b0;
    rmode  = 0;

    send_cmd(5, 0, 1, 1'b0);
    send_cmd(2, 3, 1, 1'b1);

    send_cmd(7, DEPTH, 1, 1'b1);

    @(posedge clock);
    #1;
    cmdValid = 1'b1;
    cmdBase  = AW'(0);
    cmdCount = (AW+1)'(6);
`ifdef MEMORY_STREAM_READER_STRIDE_EN
    cmdStride = AW'(1);
`endif
    for (int k = 0; k < 6; k++) sb.push_back('{data: WIDTH'(100 + k), last: (k == 5), cyc: -1});
    p0 = n_pop;
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
    w = 0;
    while (n_pop < p0 + 2 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("reset_two_popped", 64'(n_pop - p0), 64'd2);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    sb.delete();
    #1;
    check("midrst_outValid", 64'(outValid), 64'd0);
    check("midrst_cmdReady", 64'(cmdReady), 64'd1);
    check("midrst_memAddress", 64'(memAddress), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    p0 = n_pop;
    send_cmd(0, 2, 1, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    check("post_reset_words", 64'(n_pop - p0), 64'd2);

`ifdef MEMORY_STREAM_READER_STRIDE_EN
    send_cmd(1, 4, 5, 1'b1);
    send_cmd(9, 3, 0, 1'b1);
`endif

    rmode = 1;
    for (int t = 0; t < 40; t++) begin
      base  = int'($urandom_range(0, DEPTH - 1));
      count = int'($urandom_range(0, DEPTH));
`ifdef MEMORY_STREAM_READER_STRIDE_EN
      stride = int'($urandom_range(0, DEPTH - 1));
`else
      stride = 1;
`endif
      send_cmd(base, count, stride, 1'b0);
    end
    rmode = 0;
    repeat (3) @(posedge clock);
    #1;
    check("final_idle", 64'(cmdReady), 64'd1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    check("final_memWriteEnable", 64'(memWriteEnable), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
